// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
//   mem_typ_e   : access size/extension codes carried on dmem_req_typ
//   mem_fcn_e   : load/store selector carried on dmem_req_fcn
//   mem_owner_e : which core port owns the outstanding transaction
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_D  = 3'd4,
    MT_BU = 3'd5,
    MT_HU = 3'd6,
    MT_WU = 3'd7
  } mem_typ_e;

  typedef enum logic {
    FCN_LD = 1'b0,
    FCN_ST = 1'b1
  } mem_fcn_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } mem_owner_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for a 32-bit, 4-lane memory port (purely combinational).
//   typ     : access type (mem_typ_e code)
//   addr_lo : byte offset within the word
//   st_data : right-justified store data
//   rd_word : raw word returned by the backing memory
//   wmask   : byte-lane write mask
//   wdata   : store data replicated onto the addressed lanes
//   ld_data : load data shifted down and sign/zero extended
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  typ,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] rd_word,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rd_word >> {addr_lo, 3'b000};
    wmask   = 4'b1111;
    wdata   = st_data;
    ld_data = shifted;
    case (mem_typ_e'(typ))
      MT_B: begin
        wmask   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      MT_BU: begin
        wmask   = 4'b0001 << addr_lo;
        wdata   = {4{st_data[7:0]}};
        ld_data = {24'b0, shifted[7:0]};
      end
      MT_H: begin
        wmask   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      MT_HU: begin
        wmask   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{st_data[15:0]}};
        ld_data = {16'b0, shifted[15:0]};
      end
      default: begin
        wmask   = 4'b1111;
        wdata   = st_data;
        ld_data = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) to single backing-memory arbiter, one
// transaction outstanding, with byte-lane alignment of stores and loads.
// Optional macro: MEM_ARBITER_ROUND_ROBIN_EN (round-robin on contention;
// default is fixed dmem-over-imem priority).
// Ports:
//   clk, reset (async, active low)
//   imem_req_* / imem_res_* : instruction fetch request/response
//   dmem_req_* / dmem_res_* : data load/store request/response
//   mem_req_* / mem_res_*   : shared backing-memory port
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_req_valid,
  output logic              imem_req_ready,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_res_valid,
  output logic [DATA_W-1:0] imem_res_data,
  input  logic              dmem_req_valid,
  output logic              dmem_req_ready,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic              dmem_req_fcn,
  input  logic [2:0]        dmem_req_typ,
  input  logic [DATA_W-1:0] dmem_req_data,
  output logic              dmem_res_valid,
  output logic [DATA_W-1:0] dmem_res_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [3:0]        mem_req_wmask,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_res_valid,
  input  logic [DATA_W-1:0] mem_res_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e            state_q, state_d;
  mem_owner_e        owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        typ_q;

  logic              grant_d, grant_i;
  logic              resp;

  logic [2:0]        al_typ;
  logic [1:0]        al_addr_lo;
  logic [3:0]        al_wmask;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld_data;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  mem_owner_e        last_q;
`endif

  // Grant only in IDLE and never while reset is asserted.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (reset && state_q == IDLE) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      if (dmem_req_valid && imem_req_valid) begin
        if (last_q == OWN_DMEM) grant_i = 1'b1;
        else                    grant_d = 1'b1;
      end else begin
        grant_d = dmem_req_valid;
        grant_i = imem_req_valid;
      end
`else
      grant_d = dmem_req_valid;
      grant_i = imem_req_valid && !dmem_req_valid;
`endif
    end
  end

  assign dmem_req_ready = grant_d;
  assign imem_req_ready = grant_i;

  // One aligner serves both directions: in IDLE it shapes the incoming
  // store, afterwards it extends the returning load using latched fields.
  assign al_typ     = (state_q == IDLE) ? dmem_req_typ       : typ_q;
  assign al_addr_lo = (state_q == IDLE) ? dmem_req_addr[1:0] : addr_q[1:0];

  mem_lane_align u_align (
    .typ     (al_typ),
    .addr_lo (al_addr_lo),
    .st_data (dmem_req_data),
    .rd_word (mem_res_data),
    .wmask   (al_wmask),
    .wdata   (al_wdata),
    .ld_data (al_ld_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_d || grant_i) state_d = ISSUE;
      ISSUE:   if (mem_req_ready)      state_d = WAIT;
      WAIT:    if (mem_res_valid)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_DMEM;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wmask_q <= '0;
      wdata_q <= '0;
      typ_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_d) begin
        owner_q <= OWN_DMEM;
        addr_q  <= dmem_req_addr;
        we_q    <= dmem_req_fcn;
        wmask_q <= (dmem_req_fcn == FCN_ST) ? al_wmask : '0;
        wdata_q <= (dmem_req_fcn == FCN_ST) ? al_wdata : '0;
        typ_q   <= dmem_req_typ;
      end else if (grant_i) begin
        owner_q <= OWN_IMEM;
        addr_q  <= imem_req_addr;
        we_q    <= 1'b0;
        wmask_q <= '0;
        wdata_q <= '0;
        typ_q   <= MT_W;
      end
    end
  end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= OWN_DMEM;
    end else if (grant_d) begin
      last_q <= OWN_DMEM;
    end else if (grant_i) begin
      last_q <= OWN_IMEM;
    end
  end
`endif

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_req_we    = we_q;
  assign mem_req_wmask = wmask_q;
  assign mem_req_wdata = wdata_q;

  assign resp           = (state_q == WAIT) && mem_res_valid;
  assign imem_res_valid = resp && (owner_q == OWN_IMEM);
  assign dmem_res_valid = resp && (owner_q == OWN_DMEM);
  assign imem_res_data  = imem_res_valid ? mem_res_data : '0;
  assign dmem_res_data  = (dmem_res_valid && !we_q) ? al_ld_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid = 1'b0;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr = '0;
  logic        imem_res_valid;
  logic [31:0] imem_res_data;
  logic        dmem_req_valid = 1'b0;
  logic        dmem_req_ready;
  logic [31:0] dmem_req_addr = '0;
  logic        dmem_req_fcn = 1'b0;
  logic [2:0]  dmem_req_typ = '0;
  logic [31:0] dmem_req_data = '0;
  logic        dmem_res_valid;
  logic [31:0] dmem_res_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [3:0]  mem_req_wmask;
  logic [31:0] mem_req_wdata;
  logic        mem_res_valid = 1'b0;
  logic [31:0] mem_res_data = '0;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_res_valid(imem_res_valid),
    .imem_res_data(imem_res_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_fcn(dmem_req_fcn),
    .dmem_req_typ(dmem_req_typ), .dmem_req_data(dmem_req_data),
    .dmem_res_valid(dmem_res_valid), .dmem_res_data(dmem_res_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wmask(mem_req_wmask), .mem_req_wdata(mem_req_wdata),
    .mem_res_valid(mem_res_valid), .mem_res_data(mem_res_data)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // From ISSUE: accept the request for one cycle, leaving the DUT in WAIT.
  task automatic issue_and_wait;
    mem_req_ready = 1'b1;
    step;
    mem_req_ready = 1'b0;
  endtask

  task automatic test_reset;
    imem_req_valid = 1'b1;
    dmem_req_valid = 1'b1;
    #2;
    checks++;
    if ({imem_req_ready, dmem_req_ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b expected 00", {imem_req_ready, dmem_req_ready});
    end
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata} !== '0) begin
      errors++; $display("FAIL reset_mem_req: valid=%b addr=%h we=%b mask=%b wdata=%h expected all 0",
                         mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata);
    end
    checks++;
    if ({imem_res_valid, imem_res_data, dmem_res_valid, dmem_res_data} !== '0) begin
      errors++; $display("FAIL reset_res: got %b/%h %b/%h expected all 0",
                         imem_res_valid, imem_res_data, dmem_res_valid, dmem_res_data);
    end
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    step;
    reset = 1'b1;
    step;
  endtask

  task automatic test_imem_read;
    imem_req_valid = 1'b1;
    imem_req_addr  = 32'h100;
    #1;
    checks++;
    if ({imem_req_ready, dmem_req_ready} !== 2'b10) begin
      errors++; $display("FAIL imem_grant_ready: got %b expected 10", {imem_req_ready, dmem_req_ready});
    end
    step;
    imem_req_valid = 1'b0;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr} !== {1'b1, 32'h100}) begin
      errors++; $display("FAIL imem_issue: got valid=%b addr=%h expected 1/00000100", mem_req_valid, mem_req_addr);
    end
    checks++;
    if ({mem_req_we, mem_req_wmask} !== 5'b0) begin
      errors++; $display("FAIL imem_we_mask: got %b/%b expected 0/0000", mem_req_we, mem_req_wmask);
    end
    issue_and_wait;
    checks++;
    if ({mem_req_valid, imem_req_ready} !== 2'b00) begin
      errors++; $display("FAIL imem_wait_idle_outs: got %b expected 00", {mem_req_valid, imem_req_ready});
    end
    step;
    checks++;
    if (imem_res_valid !== 1'b0) begin
      errors++; $display("FAIL imem_no_early_res: got %b expected 0", imem_res_valid);
    end
    mem_res_valid = 1'b1;
    mem_res_data  = 32'hDEADBEEF;
    #1;
    checks++;
    if ({imem_res_valid, imem_res_data, dmem_res_valid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      errors++; $display("FAIL imem_res: got %b/%h dmem=%b expected 1/deadbeef dmem=0",
                         imem_res_valid, imem_res_data, dmem_res_valid);
    end
    step;
    #1;
    checks++;
    if (imem_res_valid !== 1'b0) begin
      errors++; $display("FAIL imem_res_pulse: got %b expected 0", imem_res_valid);
    end
    mem_res_valid = 1'b0;
  endtask

  task automatic test_store;
    logic [2:0]  typ_t  [5] = '{MT_B, MT_B, MT_H, MT_H, MT_W};
    logic [31:0] addr_t [5] = '{32'h203, 32'h201, 32'h202, 32'h200, 32'h204};
    logic [31:0] data_t [5] = '{32'hAB, 32'h5A, 32'h1234, 32'hBEEF, 32'hCAFEF00D};
    logic [31:0] eadr_t [5] = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h204};
    logic [3:0]  emsk_t [5] = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111};
    logic [31:0] ewd_t  [5] = '{32'hABABABAB, 32'h5A5A5A5A, 32'h12341234, 32'hBEEFBEEF, 32'hCAFEF00D};
    for (int i = 0; i < 5; i++) begin
      dmem_req_valid = 1'b1;
      dmem_req_fcn   = FCN_ST;
      dmem_req_typ   = typ_t[i];
      dmem_req_addr  = addr_t[i];
      dmem_req_data  = data_t[i];
      #1;
      checks++;
      if (dmem_req_ready !== 1'b1) begin
        errors++; $display("FAIL store%0d_ready: got %b expected 1", i, dmem_req_ready);
      end
      step;
      dmem_req_valid = 1'b0;
      #1;
      checks++;
      if ({mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata} !== {eadr_t[i], 1'b1, emsk_t[i], ewd_t[i]}) begin
        errors++; $display("FAIL store%0d_req: got addr=%h we=%b mask=%b wdata=%h expected %h/1/%b/%h",
                           i, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata, eadr_t[i], emsk_t[i], ewd_t[i]);
      end
      issue_and_wait;
      mem_res_valid = 1'b1;
      mem_res_data  = 32'h55555555;
      #1;
      checks++;
      if ({dmem_res_valid, dmem_res_data, imem_res_valid} !== {1'b1, 32'h0, 1'b0}) begin
        errors++; $display("FAIL store%0d_ack: got %b/%h imem=%b expected 1/00000000 imem=0",
                           i, dmem_res_valid, dmem_res_data, imem_res_valid);
      end
      step;
      mem_res_valid = 1'b0;
    end
  endtask

  task automatic test_load;
    logic [2:0]  typ_t  [7] = '{MT_H, MT_HU, MT_B, MT_BU, MT_B, MT_H, MT_W};
    logic [31:0] addr_t [7] = '{32'h202, 32'h202, 32'h203, 32'h201, 32'h200, 32'h200, 32'h208};
    logic [31:0] raw_t  [7] = '{32'h80011234, 32'h80011234, 32'h80FF0000, 32'h12345678,
                                32'h0000007F, 32'h0000F00F, 32'h89ABCDEF};
    logic [31:0] exp_t  [7] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'h00000056,
                                32'h0000007F, 32'hFFFFF00F, 32'h89ABCDEF};
    for (int i = 0; i < 7; i++) begin
      dmem_req_valid = 1'b1;
      dmem_req_fcn   = FCN_LD;
      dmem_req_typ   = typ_t[i];
      dmem_req_addr  = addr_t[i];
      dmem_req_data  = 32'hFFFFFFFF;
      #1;
      step;
      dmem_req_valid = 1'b0;
      #1;
      checks++;
      if ({mem_req_addr, mem_req_we, mem_req_wmask} !== {addr_t[i] & 32'hFFFFFFFC, 1'b0, 4'b0000}) begin
        errors++; $display("FAIL load%0d_req: got addr=%h we=%b mask=%b expected %h/0/0000",
                           i, mem_req_addr, mem_req_we, mem_req_wmask, addr_t[i] & 32'hFFFFFFFC);
      end
      issue_and_wait;
      mem_res_valid = 1'b1;
      mem_res_data  = raw_t[i];
      #1;
      checks++;
      if ({dmem_res_valid, dmem_res_data, imem_res_valid} !== {1'b1, exp_t[i], 1'b0}) begin
        errors++; $display("FAIL load%0d_data: got %b/%h imem=%b expected 1/%h imem=0",
                           i, dmem_res_valid, dmem_res_data, imem_res_valid, exp_t[i]);
      end
      step;
      mem_res_valid = 1'b0;
    end
  endtask

  task automatic test_stall;
    dmem_req_valid = 1'b1;
    dmem_req_fcn   = FCN_ST;
    dmem_req_typ   = MT_W;
    dmem_req_addr  = 32'h300;
    dmem_req_data  = 32'h600DF00D;
    #1;
    step;
    dmem_req_valid = 1'b0;
    // Stale response while still in ISSUE must be ignored.
    mem_res_valid  = 1'b1;
    mem_res_data   = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata} !==
          {1'b1, 32'h300, 1'b1, 4'b1111, 32'h600DF00D}) begin
        errors++; $display("FAIL stall%0d_fields: got v=%b addr=%h we=%b mask=%b wdata=%h expected 1/300/1/1111/600df00d",
                           c, mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata);
      end
      checks++;
      if ({imem_res_valid, dmem_res_valid, dmem_req_ready} !== 3'b000) begin
        errors++; $display("FAIL stall%0d_no_res: got %b expected 000", c, {imem_res_valid, dmem_res_valid, dmem_req_ready});
      end
      step;
    end
    mem_res_valid = 1'b0;
    issue_and_wait;
    mem_res_valid = 1'b1;
    mem_res_data  = 32'h13579BDF;
    #1;
    checks++;
    if ({dmem_res_valid, dmem_res_data} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL stall_ack: got %b/%h expected 1/00000000", dmem_res_valid, dmem_res_data);
    end
    step;
    mem_res_valid = 1'b0;
  endtask

  task automatic test_contention;
    logic exp_i;
    imem_req_addr = 32'h400;
    dmem_req_addr = 32'h500;
    dmem_req_fcn  = FCN_LD;
    dmem_req_typ  = MT_W;
    for (int k = 0; k < 4; k++) begin
      imem_req_valid = 1'b1;
      dmem_req_valid = 1'b1;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_i = (k % 2 == 0);
`else
      exp_i = 1'b0;
`endif
      #1;
      checks++;
      if ({imem_req_ready, dmem_req_ready} !== {exp_i, ~exp_i}) begin
        errors++; $display("FAIL contend%0d_ready: got %b expected %b", k, {imem_req_ready, dmem_req_ready}, {exp_i, ~exp_i});
      end
      step;
      #1;
      checks++;
      if (mem_req_addr !== (exp_i ? 32'h400 : 32'h500)) begin
        errors++; $display("FAIL contend%0d_addr: got %h expected %h", k, mem_req_addr, exp_i ? 32'h400 : 32'h500);
      end
      issue_and_wait;
      mem_res_valid = 1'b1;
      mem_res_data  = 32'h0A0B0C0D;
      #1;
      checks++;
      if ({imem_res_valid, dmem_res_valid, imem_req_ready, dmem_req_ready} !== {exp_i, ~exp_i, 2'b00}) begin
        errors++; $display("FAIL contend%0d_res: got %b expected %b", k,
                           {imem_res_valid, dmem_res_valid, imem_req_ready, dmem_req_ready}, {exp_i, ~exp_i, 2'b00});
      end
      step;
      mem_res_valid = 1'b0;
    end
    dmem_req_valid = 1'b0;
    #1;
    checks++;
    if ({imem_req_ready, dmem_req_ready} !== 2'b10) begin
      errors++; $display("FAIL contend_imem_served: got %b expected 10", {imem_req_ready, dmem_req_ready});
    end
    step;
    imem_req_valid = 1'b0;
    issue_and_wait;
    mem_res_valid = 1'b1;
    mem_res_data  = 32'h0;
    step;
    mem_res_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    dmem_req_valid = 1'b1;
    dmem_req_fcn   = FCN_LD;
    dmem_req_typ   = MT_W;
    dmem_req_addr  = 32'h600;
    #1;
    step;
    issue_and_wait;
    #2;
    reset = 1'b0;
    mem_res_valid = 1'b1;
    mem_res_data  = 32'h77777777;
    #1;
    checks++;
    if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata} !== '0) begin
      errors++; $display("FAIL midreset_mem_req: v=%b addr=%h we=%b mask=%b wdata=%h expected all 0",
                         mem_req_valid, mem_req_addr, mem_req_we, mem_req_wmask, mem_req_wdata);
    end
    checks++;
    if ({imem_req_ready, dmem_req_ready, imem_res_valid, dmem_res_valid, dmem_res_data} !== '0) begin
      errors++; $display("FAIL midreset_ports: got %b %h expected 0",
                         {imem_req_ready, dmem_req_ready, imem_res_valid, dmem_res_valid}, dmem_res_data);
    end
    dmem_req_valid = 1'b0;
    step;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({imem_res_valid, dmem_res_valid} !== 2'b00) begin
        errors++; $display("FAIL stale_res%0d: got %b expected 00", c, {imem_res_valid, dmem_res_valid});
      end
      step;
    end
    mem_res_valid = 1'b0;
    imem_req_valid = 1'b1;
    imem_req_addr  = 32'h700;
    #1;
    checks++;
    if (imem_req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_grant: got %b expected 1", imem_req_ready);
    end
    step;
    imem_req_valid = 1'b0;
    issue_and_wait;
    mem_res_valid = 1'b1;
    step;
    mem_res_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_imem_read;
    test_store;
    test_load;
    test_stall;
    test_contention;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
